// File: rtl/hdmi_framebuffer_controller.sv
// rtl/hdmi_framebuffer_controller.sv - double-buffered 320x240 RGB332 framebuffer with 640x480 timing and AXI-Lite control
`timescale 1ns/1ps
module hdmi_framebuffer_controller #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 14,
  // Video timing in output pixels; defaults give 640x480@60
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic                          axi_aclk,
  input  logic                          axi_areset,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_awaddr,
  input  logic [2:0]                    axi_awprot,
  input  logic                          axi_awvalid,
  output logic                          axi_awready,
  input  logic [C_AXI_DATA_WIDTH-1:0]   axi_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] axi_wstrb,
  input  logic                          axi_wvalid,
  output logic                          axi_wready,
  output logic [1:0]                    axi_bresp,
  output logic                          axi_bvalid,
  input  logic                          axi_bready,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_araddr,
  input  logic [2:0]                    axi_arprot,
  input  logic                          axi_arvalid,
  output logic                          axi_arready,
  output logic [C_AXI_DATA_WIDTH-1:0]   axi_rdata,
  output logic [1:0]                    axi_rresp,
  output logic                          axi_rvalid,
  input  logic                          axi_rready,
  input  logic                          wea,
  input  logic [16:0]                   addra,
  input  logic [7:0]                    dina,
  output logic                          clk_25MHz,
  output logic                          hsync,
  output logic                          vsync,
  output logic                          vde,
  output logic [9:0]                    drawX,
  output logic [9:0]                    drawY,
  output logic [3:0]                    red,
  output logic [3:0]                    green,
  output logic [3:0]                    blue,
  output logic                          locked
);

  localparam int         FB_WORDS = 76800;
  localparam logic [16:0] FB_DEPTH = 17'd76800;
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] H_SS   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] V_SS   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [1:0]  phase_q;
  logic [3:0]  lock_cnt_q;
  logic        locked_q;
  logic [9:0]  hcount_q, vcount_q;
  logic        front_sel_q, auto_swap_q, swap_req_q;
  logic [15:0] frame_cnt_q;
  logic [7:0]  ram0_mem [FB_WORDS];
  logic [7:0]  ram1_mem [FB_WORDS];
  logic [7:0]  rd0_q, rd1_q;
  logic [3:0]  red_q, green_q, blue_q;
  logic        awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  logic [C_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [16:0] rd_addr_d;

  logic pix_adv, h_wrap, active, swap_evt, wr_en, wr_go, rd_go, ctrl_wr;
  logic [7:0] pix;

  assign pix_adv  = locked_q && (phase_q == 2'd3);
  assign h_wrap   = (hcount_q == H_LAST);
  // The swap lands on the edge where vcount steps into the vsync region
  assign swap_evt = pix_adv && h_wrap && (vcount_q == V_SS - 10'd1);
  assign active   = locked_q && (hcount_q < H_ACT) && (vcount_q < V_ACT);
  assign wr_en    = wea && (addra < FB_DEPTH);
  assign wr_go    = awready_q && axi_awvalid && axi_wvalid;
  assign rd_go    = arready_q && axi_arvalid;
  assign ctrl_wr  = wr_go && (axi_awaddr[3:2] == 2'd0) && axi_wstrb[0];
  assign pix      = front_sel_q ? rd1_q : rd0_q;

  assign clk_25MHz   = phase_q[1];
  assign hsync       = !((hcount_q >= H_SS) && (hcount_q < H_SE));
  assign vsync       = !((vcount_q >= V_SS) && (vcount_q < V_SE));
  assign vde         = active;
  assign drawX       = hcount_q;
  assign drawY       = vcount_q;
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign locked      = locked_q;
  assign axi_awready = awready_q;
  assign axi_wready  = wready_q;
  assign axi_bvalid  = bvalid_q;
  assign axi_bresp   = 2'b00;
  assign axi_arready = arready_q;
  assign axi_rvalid  = rvalid_q;
  assign axi_rdata   = rdata_q;
  assign axi_rresp   = 2'b00;

  logic unused_ok;
  assign unused_ok = ^{axi_awprot, axi_arprot, axi_awaddr[C_AXI_ADDR_WIDTH-1:4], axi_awaddr[1:0],
                       axi_araddr[C_AXI_ADDR_WIDTH-1:4], axi_araddr[1:0],
                       axi_wstrb[C_AXI_DATA_WIDTH/8-1:1], axi_wdata[C_AXI_DATA_WIDTH-1:2]};

  // Front-buffer address for the current pixel, 2x doubled in both directions
  always_comb begin
    rd_addr_d = '0;
    if (active) begin
      rd_addr_d = {vcount_q[9:1], 8'b0} + {2'b0, vcount_q[9:1], 6'b0} + {8'b0, hcount_q[9:1]};
    end
  end

  // Register read mux, sampled on the read-address handshake
  always_comb begin
    rdata_d = '0;
    case (axi_araddr[3:2])
      2'd0:    rdata_d = {30'b0, swap_req_q, auto_swap_q};
      2'd1:    rdata_d = {frame_cnt_q, 14'b0, locked_q, front_sel_q};
      default: rdata_d = '0;
    endcase
  end

  // Pixel phase, lock delay and raster counters; raster holds until locked
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      phase_q    <= 2'd0;
      lock_cnt_q <= 4'd0;
      locked_q   <= 1'b0;
      hcount_q   <= 10'd0;
      vcount_q   <= 10'd0;
    end else begin
      phase_q <= phase_q + 2'd1;
      if (!locked_q) begin
        lock_cnt_q <= lock_cnt_q + 4'd1;
        if (lock_cnt_q == 4'd15) locked_q <= 1'b1;
      end
      if (pix_adv) begin
        if (h_wrap) begin
          hcount_q <= 10'd0;
          vcount_q <= (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;
        end else begin
          hcount_q <= hcount_q + 10'd1;
        end
      end
    end
  end

  // Buffer swap and CTRL register; a swap_req written on the swap cycle survives the clear
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      front_sel_q <= 1'b0;
      auto_swap_q <= 1'b1;
      swap_req_q  <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      if (swap_evt) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
        if (auto_swap_q || swap_req_q) front_sel_q <= !front_sel_q;
        swap_req_q <= 1'b0;
      end
      if (ctrl_wr) begin
        auto_swap_q <= axi_wdata[0];
        if (axi_wdata[1]) swap_req_q <= 1'b1;
      end
    end
  end

  // Buffer 0: GPU writes while it is the back buffer; video read at phase 0
  always_ff @(posedge axi_aclk) begin
    if (wr_en && front_sel_q) ram0_mem[addra] <= dina;
    if (phase_q == 2'd0) rd0_q <= ram0_mem[rd_addr_d];
  end

  // Buffer 1: GPU writes while it is the back buffer; video read at phase 0
  always_ff @(posedge axi_aclk) begin
    if (wr_en && !front_sel_q) ram1_mem[addra] <= dina;
    if (phase_q == 2'd0) rd1_q <= ram1_mem[rd_addr_d];
  end

  // RGB332 to 4:4:4 expansion at phase 1 so colour is settled at the pixel clock rise
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      red_q   <= 4'd0;
      green_q <= 4'd0;
      blue_q  <= 4'd0;
    end else if (phase_q == 2'd1) begin
      red_q   <= active ? {pix[7:5], pix[7]} : 4'd0;
      green_q <= active ? {pix[4:2], pix[4]} : 4'd0;
      blue_q  <= active ? {pix[1:0], pix[1:0]} : 4'd0;
    end
  end

  // AXI-Lite handshakes: single-cycle ready pulses, valids held until accepted
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      awready_q <= axi_awvalid && axi_wvalid && !bvalid_q && !awready_q;
      wready_q  <= axi_awvalid && axi_wvalid && !bvalid_q && !awready_q;
      if (wr_go) bvalid_q <= 1'b1;
      else if (bvalid_q && axi_bready) bvalid_q <= 1'b0;
      arready_q <= axi_arvalid && !rvalid_q && !arready_q;
      if (rd_go) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rdata_d;
      end else if (rvalid_q && axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hdmi_framebuffer_controller.sv
// tb/tb_hdmi_framebuffer_controller.sv - self-checking bench for hdmi_framebuffer_controller
`timescale 1ns/1ps
module tb_hdmi_framebuffer_controller;

  // Shrunken raster keeps frames short; buffer geometry is unchanged
  localparam int HA = 24, HF = 2, HS = 4, HB = 2;
  localparam int VA = 24, VF = 2, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME_CYC = HT * VT * 4;

  logic axi_aclk, axi_areset;
  logic [13:0] axi_awaddr, axi_araddr;
  logic [2:0] axi_awprot, axi_arprot;
  logic axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
  logic [31:0] axi_wdata, axi_rdata;
  logic [3:0] axi_wstrb;
  logic [1:0] axi_bresp, axi_rresp;
  logic axi_arvalid, axi_arready, axi_rvalid, axi_rready;
  logic wea;
  logic [16:0] addra;
  logic [7:0] dina;
  logic clk_25MHz, hsync, vsync, vde, locked;
  logic [9:0] drawX, drawY;
  logic [3:0] red, green, blue;

  hdmi_framebuffer_controller #(
    .C_AXI_DATA_WIDTH(32), .C_AXI_ADDR_WIDTH(14),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .axi_aclk(axi_aclk), .axi_areset(axi_areset),
    .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .wea(wea), .addra(addra), .dina(dina),
    .clk_25MHz(clk_25MHz), .hsync(hsync), .vsync(vsync), .vde(vde),
    .drawX(drawX), .drawY(drawY), .red(red), .green(green), .blue(blue), .locked(locked)
  );

  initial begin
    axi_aclk = 1'b0;
    forever #5 axi_aclk = ~axi_aclk;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboards: AXI read data and expected pixels {x[9:0], y[9:0], rgb[11:0]} in raster order
  logic [31:0] rd_q[$];
  logic [31:0] pix_q[$];

  // Reference model of buffer selection and frame counting
  logic m_auto, m_req, m_front;
  logic [15:0] m_fc;
  logic prev_vs, prev_c25, vs_fell, vs_rose, c25_rise;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] status_exp();
    return {m_fc, 14'b0, 1'b1, m_front};
  endfunction

  task automatic tick();
    @(negedge axi_aclk);
    vs_fell = 1'b0;
    vs_rose = 1'b0;
    if (axi_areset) begin
      m_auto = 1'b1; m_req = 1'b0; m_front = 1'b0; m_fc = 16'd0;
      prev_vs = 1'b1; prev_c25 = 1'b0; c25_rise = 1'b0;
    end else begin
      vs_fell = prev_vs && !vsync;
      vs_rose = !prev_vs && vsync;
      if (vs_fell) begin
        m_fc = m_fc + 16'd1;
        if (m_auto || m_req) m_front = !m_front;
        m_req = 1'b0;
      end
      prev_vs  = vsync;
      c25_rise = !prev_c25 && clk_25MHz;
      prev_c25 = clk_25MHz;
    end
  endtask

  task automatic wait_fall();
    int n = 0;
    do begin tick(); n++; end while (!vs_fell && n < 3 * FRAME_CYC);
    check("vsync_fall_seen", vs_fell, 1);
  endtask

  task automatic wait_rise();
    int n = 0;
    do begin tick(); n++; end while (!vs_rose && n < 3 * FRAME_CYC);
    check("vsync_rise_seen", vs_rose, 1);
  endtask

  task automatic axi_write(input logic [13:0] addr, input logic [31:0] data, input logic [3:0] strb, input logic rdy);
    int n = 0;
    axi_awaddr = addr; axi_wdata = data; axi_wstrb = strb;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_bready = rdy;
    do begin tick(); n++; end while (!axi_awready && n < 50);
    check("aw_ready", {axi_awready, axi_wready}, 2'b11);
    tick();
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    check("b_valid", axi_bvalid, 1);
    check("b_resp", axi_bresp, 0);
    if (strb[0] && addr[3:2] == 2'd0) begin
      m_auto = data[0];
      if (data[1]) m_req = 1'b1;
    end
    if (rdy) begin
      tick();
      check("b_valid_clear", axi_bvalid, 0);
    end
  endtask

  task automatic axi_read(input logic [13:0] addr, input logic [31:0] exp, input string tag);
    int n = 0;
    rd_q.push_back(exp);
    axi_araddr = addr; axi_arvalid = 1'b1; axi_rready = 1'b1;
    do begin tick(); n++; end while (!axi_arready && n < 50);
    check("ar_ready", axi_arready, 1);
    tick();
    axi_arvalid = 1'b0;
    n = 0;
    while (!axi_rvalid && n < 50) begin tick(); n++; end
    check({tag, "_rvalid"}, axi_rvalid, 1);
    if (rd_q.size() > 0) check(tag, axi_rdata, rd_q.pop_front());
    check("r_resp", axi_rresp, 0);
    tick();
    check("r_valid_clear", axi_rvalid, 0);
  endtask

  task automatic scan_frame(input string tag);
    int blank_bad = 0;
    logic [31:0] e;
    for (int i = 0; i < FRAME_CYC + 8; i++) begin
      tick();
      if (c25_rise) begin
        if (!vde) begin
          if ({red, green, blue} != 12'h000) blank_bad++;
        end else if (pix_q.size() > 0) begin
          e = pix_q[0];
          if (drawX == e[31:22] && drawY == e[21:12]) begin
            void'(pix_q.pop_front());
            check(tag, {20'b0, red, green, blue}, {20'b0, e[11:0]});
          end
        end
      end
    end
    check({tag, "_unseen"}, pix_q.size(), 0);
    check({tag, "_blank_rgb"}, blank_bad, 0);
    pix_q.delete();
  endtask

  task automatic wait_lock(input string tag);
    int n = 0;
    while (!locked && n < 100) begin tick(); n++; end
    check(tag, n, 16);
  endtask

  initial begin
    int lo;
    int n;
    time t0;
    axi_areset = 1'b1;
    axi_awaddr = '0; axi_araddr = '0; axi_awprot = '0; axi_arprot = '0;
    axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_wdata = '0; axi_wstrb = '0;
    axi_bready = 1'b0; axi_arvalid = 1'b0; axi_rready = 1'b0;
    wea = 1'b0; addra = '0; dina = '0;
    repeat (3) tick();

    check("rst_syncs", {hsync, vsync}, 2'b11);
    check("rst_vde_lock_clk", {vde, locked, clk_25MHz}, 3'b000);
    check("rst_draw", {drawX, drawY}, 0);
    check("rst_rgb", {red, green, blue}, 0);
    check("rst_axi", {axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid}, 0);

    axi_areset = 1'b0;
    wait_lock("lock_latency");

    n = 0;
    do begin tick(); n++; end while (!c25_rise && n < 20);
    t0 = $time;
    n = 0;
    do begin tick(); n++; end while (!c25_rise && n < 20);
    check("clk25_period_ns", 32'($time - t0), 40);

    lo = 0;
    for (int i = 0; i < HT * 4; i++) begin tick(); if (!hsync) lo++; end
    check("hsync_low_cycles", lo, HS * 4);

    axi_read(14'h0, 32'h1, "ctrl_reset");
    axi_read(14'h4, status_exp(), "status_reset");

    lo = 0;
    for (int i = 0; i < FRAME_CYC; i++) begin tick(); if (!vsync) lo++; end
    check("vsync_low_cycles", lo, VS * HT * 4);

    // Single red pixel becomes a 2x2 block after the next swap
    wait_fall();
    wait_rise();
    wea = 1'b1; addra = 17'(10 * 320 + 10); dina = 8'hE0;
    tick();
    wea = 1'b0;
    pix_q.push_back({10'd20, 10'd20, 12'hF00});
    pix_q.push_back({10'd21, 10'd20, 12'hF00});
    pix_q.push_back({10'd20, 10'd21, 12'hF00});
    pix_q.push_back({10'd21, 10'd21, 12'hF00});
    wait_fall();
    scan_frame("red_px");

    // Fill visible part of the back buffer with 0x01; an out-of-range write must be dropped
    wait_rise();
    wea = 1'b1;
    for (int y = 0; y < VA / 2; y++) begin
      for (int x = 0; x < HA / 2; x++) begin
        addra = 17'(y * 320 + x); dina = 8'h01;
        tick();
      end
    end
    addra = 17'd76800; dina = 8'hFF;
    tick();
    wea = 1'b0;
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++)
        pix_q.push_back({10'(x), 10'(y), 12'h005});
    wait_fall();
    scan_frame("blue_px");

    // Manual mode: no swaps across two frames, then one requested swap
    wait_rise();
    axi_write(14'h0, 32'h0, 4'h1, 1'b1);
    axi_read(14'h4, status_exp(), "status_manual_a");
    wait_fall();
    wait_fall();
    wait_rise();
    axi_read(14'h4, status_exp(), "status_manual_b");
    axi_write(14'h0, 32'h2, 4'h1, 1'b1);
    axi_read(14'h0, 32'h2, "ctrl_req_pending");
    wait_fall();
    wait_rise();
    axi_read(14'h0, 32'h0, "ctrl_req_cleared");
    axi_read(14'h4, status_exp(), "status_after_req");
    axi_write(14'h0, 32'h1, 4'h0, 1'b1);
    axi_read(14'h0, 32'h0, "ctrl_strb_masked");
    axi_read(14'h8, 32'h0, "reg_unmapped");

    axi_write(14'h0, 32'h0, 4'h1, 1'b0);
    repeat (5) tick();
    check("bvalid_hold", axi_bvalid, 1);
    axi_bready = 1'b1;
    tick();
    check("bvalid_release", axi_bvalid, 0);

    // Reset in the middle of active video with a write response outstanding
    axi_write(14'h0, 32'h1, 4'h1, 1'b0);
    n = 0;
    do begin tick(); n++; end while (!(vde && drawX > 10'd8) && n < 2 * FRAME_CYC);
    check("midframe_reached", vde, 1);
    axi_areset = 1'b1;
    #1;
    check("mrst_syncs", {hsync, vsync}, 2'b11);
    check("mrst_vde_lock_clk", {vde, locked, clk_25MHz}, 3'b000);
    check("mrst_draw", {drawX, drawY}, 0);
    check("mrst_rgb", {red, green, blue}, 0);
    check("mrst_axi", {axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid}, 0);
    tick();
    tick();
    axi_bready = 1'b1;
    axi_areset = 1'b0;
    wait_lock("relock_latency");
    axi_read(14'h0, 32'h1, "ctrl_post_reset");
    axi_read(14'h4, status_exp(), "status_post_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
